clk_div_scheduler: RTL and testbench

Shares one programmable clock divider between three rate requesters: the timekeeping path, the time-set fast-advance path and the stopwatch path. Drives the divider's comparand and enable, grants the divider to one requester at a time by fixed priority, and changes rate only at a tick boundary. This guarantees the divider counter never runs past a newly loaded, smaller comparand. Sits between the mode FSMs and the divider instance in the clock top level.

---
 rtl/clk_div_scheduler.sv | 143 ++++++++++++++
 tb/tb_clk_div_scheduler.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/clk_div_scheduler.sv
// rtl/clk_div_scheduler.sv - fixed-priority arbiter sharing one rate divider, rate changes only at tick boundaries
// Optional feature: CLKSCHED_HOLD_MIN_EN holds a grant for MIN_TICKS boundaries before preemption.
module clk_div_scheduler #(
    parameter int n         = 32,
    parameter int MIN_TICKS = 4
) (
    input  logic         CLOCK,
    input  logic         RESET_N,
    input  logic [2:0]   REQ,
    input  logic [n-1:0] RATE0,
    input  logic [n-1:0] RATE1,
    input  logic [n-1:0] RATE2,
    input  logic [n-1:0] DIV_COUNTER,
    output logic [n-1:0] DIV_COMPARAND,
    output logic         DIV_ENABLE,
    output logic [2:0]   GRANT,
    output logic         BUSY
);
    typedef enum logic [1:0] {IDLE, RUN, SWITCH} state_t;

    localparam logic [n-1:0] MIN_RATE = n'(2);

    state_t       state, state_nx;
    logic [n-1:0] cmp_nx;
    logic         en_nx;
    logic [2:0]   grant_nx;
    logic         busy_nx;
    logic [2:0]   winner;
    logic [n-1:0] winner_rate;
    logic [n-1:0] winner_rate_clamped;
    logic         boundary;
    logic         owner_lost;
    logic         higher_req;
    logic         hold_done;
    logic         load;

    // Lowest set bit of REQ is the winner.
    assign winner              = REQ & (~REQ + 3'd1);
    assign winner_rate_clamped = (winner_rate < MIN_RATE) ? MIN_RATE : winner_rate;
    assign boundary            = DIV_ENABLE && (DIV_COUNTER == DIV_COMPARAND);
    assign owner_lost          = ((REQ & GRANT) == 3'b000);
    assign higher_req          = |(REQ & (GRANT - 3'd1));

    always_comb begin
        winner_rate = RATE2;
        if (winner[0])
            winner_rate = RATE0;
        else if (winner[1])
            winner_rate = RATE1;
    end

`ifdef CLKSCHED_HOLD_MIN_EN
    localparam int TW = $clog2(MIN_TICKS + 1);
    localparam logic [TW-1:0] TICK_MAX = TW'(MIN_TICKS);

    logic [TW-1:0] ticks, ticks_nx;

    assign hold_done = (ticks >= TICK_MAX);

    always_comb begin
        ticks_nx = ticks;
        if (load)
            ticks_nx = '0;
        else if (state == RUN && boundary && ticks < TICK_MAX)
            ticks_nx = ticks + 1'b1;
    end

    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N)
            ticks <= '0;
        else
            ticks <= ticks_nx;
    end
`else
    assign hold_done = 1'b1;
`endif

    always_comb begin
        state_nx = state;
        cmp_nx   = DIV_COMPARAND;
        en_nx    = DIV_ENABLE;
        grant_nx = GRANT;
        busy_nx  = BUSY;
        load     = 1'b0;
        case (state)
            IDLE: begin
                if (|REQ) begin
                    load     = 1'b1;
                    state_nx = RUN;
                end
            end
            RUN: begin
                if (owner_lost || (higher_req && hold_done)) begin
                    state_nx = SWITCH;
                    busy_nx  = 1'b1;
                end
            end
            SWITCH: begin
                // Only a boundary is safe: the divider reloads to 1 on this edge.
                if (boundary) begin
                    busy_nx = 1'b0;
                    if (REQ == 3'b000) begin
                        state_nx = IDLE;
                        cmp_nx   = '0;
                        en_nx    = 1'b0;
                        grant_nx = 3'b000;
                    end else begin
                        state_nx = RUN;
                        load     = (winner != GRANT);
                    end
                end
            end
            default: begin
                state_nx = IDLE;
                cmp_nx   = '0;
                en_nx    = 1'b0;
                grant_nx = 3'b000;
                busy_nx  = 1'b0;
            end
        endcase
        if (load) begin
            cmp_nx   = winner_rate_clamped;
            grant_nx = winner;
            en_nx    = 1'b1;
        end
    end

    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            state         <= IDLE;
            DIV_COMPARAND <= '0;
            DIV_ENABLE    <= 1'b0;
            GRANT         <= 3'b000;
            BUSY          <= 1'b0;
        end else begin
            state         <= state_nx;
            DIV_COMPARAND <= cmp_nx;
            DIV_ENABLE    <= en_nx;
            GRANT         <= grant_nx;
            BUSY          <= busy_nx;
        end
    end
endmodule

// File: tb/tb_clk_div_scheduler.sv
// tb/tb_clk_div_scheduler.sv - directed and randomized checks of clk_div_scheduler against a behavioural model
module tb_clk_div_scheduler;
    localparam int N         = 32;
    localparam int MIN_TICKS = 4;

    logic         CLOCK = 1'b0;
    logic         RESET_N;
    logic [2:0]   REQ;
    logic [N-1:0] RATE0, RATE1, RATE2;
    logic [N-1:0] DIV_COUNTER;
    logic [N-1:0] DIV_COMPARAND;
    logic         DIV_ENABLE;
    logic [2:0]   GRANT;
    logic         BUSY;

    int checks   = 0;
    int failures = 0;

    // Model: owner index (-1 none), loaded comparand, switch pending, boundaries held.
    int           m_owner;
    logic [N-1:0] m_cmp;
    bit           m_pending;
    int           m_ticks;

    clk_div_scheduler #(.n(N), .MIN_TICKS(MIN_TICKS)) dut (
        .CLOCK(CLOCK), .RESET_N(RESET_N), .REQ(REQ),
        .RATE0(RATE0), .RATE1(RATE1), .RATE2(RATE2),
        .DIV_COUNTER(DIV_COUNTER), .DIV_COMPARAND(DIV_COMPARAND),
        .DIV_ENABLE(DIV_ENABLE), .GRANT(GRANT), .BUSY(BUSY)
    );

    always #5 CLOCK = ~CLOCK;

    function automatic logic [N-1:0] rate_of(int i);
        if (i == 0) return RATE0;
        if (i == 1) return RATE1;
        return RATE2;
    endfunction

    function automatic logic [N-1:0] clamp(logic [N-1:0] r);
        return (r < 2) ? N'(2) : r;
    endfunction

    function automatic int winner_of(logic [2:0] r);
        for (int i = 0; i < 3; i++)
            if (r[i]) return i;
        return -1;
    endfunction

    task automatic check(string tag, logic [N-1:0] got, logic [N-1:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_owner   = -1;
        m_cmp     = '0;
        m_pending = 0;
        m_ticks   = 0;
    endtask

    task automatic check_outputs();
        logic [2:0] g;
        g = (m_owner < 0) ? 3'b000 : 3'(1 << m_owner);
        check("grant", GRANT, g);
        check("comparand", DIV_COMPARAND, m_cmp);
        check("enable", DIV_ENABLE, N'(m_owner >= 0));
        check("busy", BUSY, N'(m_pending));
        if (DIV_ENABLE)
            check("div_bound", N'(DIV_COUNTER <= DIV_COMPARAND), N'(1));
    endtask

    // One clock: advance model from pre-edge inputs, clock, advance the divider, compare.
    task automatic step();
        int           w;
        bit           bnd;
        bit           hold_ok;
        bit           pre_en;
        logic [N-1:0] pre_cmp;
        if (!RESET_N) begin
            model_reset();
            @(posedge CLOCK);
            #1;
            check_outputs();
            return;
        end
        pre_en  = DIV_ENABLE;
        pre_cmp = DIV_COMPARAND;
        w       = winner_of(REQ);
        bnd     = (m_owner >= 0) && (DIV_COUNTER == m_cmp);
`ifdef CLKSCHED_HOLD_MIN_EN
        hold_ok = (m_ticks >= MIN_TICKS);
`else
        hold_ok = 1;
`endif
        if (m_owner < 0) begin
            if (w >= 0) begin
                m_owner = w;
                m_cmp   = clamp(rate_of(w));
                m_ticks = 0;
            end
        end else if (!m_pending) begin
            if (!REQ[m_owner] || (w < m_owner && hold_ok))
                m_pending = 1;
            if (bnd && m_ticks < MIN_TICKS)
                m_ticks++;
        end else if (bnd) begin
            m_pending = 0;
            if (w < 0) begin
                m_owner = -1;
                m_cmp   = '0;
            end else if (w != m_owner) begin
                m_owner = w;
                m_cmp   = clamp(rate_of(w));
                m_ticks = 0;
            end
        end
        @(posedge CLOCK);
        #1;
        if (pre_en)
            DIV_COUNTER = (DIV_COUNTER == pre_cmp) ? N'(1) : DIV_COUNTER + 1;
        check_outputs();
    endtask

    task automatic wait_not_busy(string tag, int bound);
        for (int i = 0; i < bound && BUSY; i++)
            step();
        check(tag, BUSY, 0);
    endtask

    task automatic wait_count(string tag, logic [N-1:0] val, int bound);
        for (int i = 0; i < bound && DIV_COUNTER != val; i++)
            step();
        check(tag, DIV_COUNTER, val);
    endtask

    initial begin
        RESET_N     = 1'b1;
        REQ         = 3'b100;
        RATE0       = 4;
        RATE1       = 7;
        RATE2       = 10;
        DIV_COUNTER = 1;
        model_reset();
        #2;
        RESET_N = 1'b0;
        #1;
        check_outputs();
        step();
        step();
        RESET_N = 1'b1;
        step();
        check("t1_grant", GRANT, 3'b100);
        check("t1_cmp", DIV_COMPARAND, 10);
        check("t1_en", DIV_ENABLE, 1);

        // Higher-priority request waits for the boundary at counter 10.
        wait_count("t2_cnt3", 3, 20);
        REQ   = 3'b101;
        RATE0 = 4;
        step();
        check("t2_busy", BUSY, 1);
        check("t2_grant_hold", GRANT, 3'b100);
        check("t2_cmp_hold", DIV_COMPARAND, 10);
        wait_not_busy("t2_settle", 20);
        check("t2_grant", GRANT, 3'b001);
        check("t2_cmp", DIV_COMPARAND, 4);

        // Release with nothing pending goes idle at the boundary.
        REQ = 3'b000;
        step();
        wait_not_busy("t3_settle", 20);
        check("t3_en", DIV_ENABLE, 0);
        check("t3_grant", GRANT, 3'b000);

        // Clamp and granted-rate changes ignored.
        RATE1 = 0;
        REQ   = 3'b010;
        step();
        check("t4_cmp_clamp", DIV_COMPARAND, 2);
        RATE1 = 50;
        repeat (6) step();
        check("t4_cmp_kept", DIV_COMPARAND, 2);
        RATE2 = 9;
        REQ   = 3'b100;
        step();
        wait_not_busy("t4_settle", 20);
        check("t4_grant2", GRANT, 3'b100);
        check("t4_cmp9", DIV_COMPARAND, 9);

        // Departed requester returns before the boundary: no reload.
        wait_count("t5_cnt2", 2, 20);
        REQ = 3'b000;
        step();
        check("t5_busy", BUSY, 1);
        RATE2 = 5;
        REQ   = 3'b100;
        wait_not_busy("t5_settle", 20);
        check("t5_grant", GRANT, 3'b100);
        check("t5_cmp", DIV_COMPARAND, 9);

        // Preemption timing.
        REQ = 3'b101;
        step();
`ifdef CLKSCHED_HOLD_MIN_EN
        check("t6_busy_held", BUSY, 0);
`else
        check("t6_busy_now", BUSY, 1);
`endif
        for (int i = 0; i < 100 && GRANT != 3'b001; i++)
            step();
        check("t6_grant", GRANT, 3'b001);

        // Asynchronous reset in SWITCH drops the pending request.
        REQ = 3'b000;
        step();
        check("t7_busy", BUSY, 1);
        #2;
        RESET_N = 1'b0;
        #1;
        model_reset();
        DIV_COUNTER = 1;
        check_outputs();
        step();
        RESET_N = 1'b1;
        step();
        check("t7_idle_grant", GRANT, 3'b000);
        check("t7_idle_busy", BUSY, 0);

        // Randomized traffic.
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 5) == 0) REQ   = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 3) == 0) RATE0 = N'($urandom_range(0, 12));
            if ($urandom_range(0, 3) == 0) RATE1 = N'($urandom_range(0, 12));
            if ($urandom_range(0, 3) == 0) RATE2 = N'($urandom_range(0, 12));
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
